// File: rtl/bnn_dot_pkg.sv
// Shared definitions for the BNN dot-product word-stream interface:
// the streamer FSM states, accumulator width and a counter-width helper.
package bnn_dot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ISSUE,
    DRAIN,
    WAIT,
    RESP
  } dot_state_t;

  localparam int ACC_W = 32;

  // Bits needed to hold 0..n, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bnn_dot_streamer.sv
// Reads N_WORDS activation/weight word pairs from two sync-read memories,
// streams them to the dot engine, and returns the engine result on a valid/ready channel.
module bnn_dot_streamer
  import bnn_dot_pkg::*;
#(
  parameter int N_BITS       = 256,
  parameter int WORD_W       = 32,
  parameter int N_WORDS      = N_BITS / WORD_W,
  parameter int ADDR_W       = 10,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_W-1:0]       cmd_a_base,
  input  logic [ADDR_W-1:0]       cmd_w_base,
  output logic                    a_rd_en,
  output logic [ADDR_W-1:0]       a_rd_addr,
  input  logic [WORD_W-1:0]       a_rd_data,
  output logic                    w_rd_en,
  output logic [ADDR_W-1:0]       w_rd_addr,
  input  logic [WORD_W-1:0]       w_rd_data,
  output logic                    start,
  output logic [WORD_W-1:0]       a_word,
  output logic [WORD_W-1:0]       w_word,
  output logic                    word_valid,
  output logic                    last_word,
  input  logic                    dot_done,
  input  logic signed [ACC_W-1:0] dot_acc,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [ACC_W-1:0] res_data,
  output logic                    res_err,
  output logic                    busy
);

  localparam int K_W = cnt_width(N_WORDS);
  localparam int T_W = cnt_width(DONE_TIMEOUT);
  localparam logic [K_W-1:0] K_LAST = K_W'(N_WORDS - 1);
  localparam logic [T_W-1:0] T_LAST = T_W'(DONE_TIMEOUT - 1);

  dot_state_t state, state_n;
  logic [ADDR_W-1:0] a_base, a_base_n, w_base, w_base_n;
  logic [ADDR_W-1:0] a_addr_n, w_addr_n;
  logic [K_W-1:0] k, k_n;
  logic [T_W-1:0] tmo, tmo_n;
  logic err, err_n;
  logic rd_en, rd_en_n, rd_last, rd_last_n, start_n, busy_n;
  logic res_valid_n, res_err_n;
  logic signed [ACC_W-1:0] res_data_n;
  logic v1, l1;

  assign cmd_ready = (state == IDLE) && rst_n;
  assign a_rd_en   = rd_en;
  assign w_rd_en   = rd_en;

  // Next-state logic; read strobes and addresses are computed one cycle
  // ahead so that every read-side output comes straight from a flop.
  always_comb begin
    state_n     = state;
    a_base_n    = a_base;
    w_base_n    = w_base;
    k_n         = k;
    tmo_n       = tmo;
    err_n       = err;
    start_n     = 1'b0;
    rd_en_n     = 1'b0;
    rd_last_n   = 1'b0;
    a_addr_n    = a_rd_addr;
    w_addr_n    = w_rd_addr;
    res_valid_n = res_valid;
    res_data_n  = res_data;
    res_err_n   = res_err;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          a_base_n  = cmd_a_base;
          w_base_n  = cmd_w_base;
          k_n       = '0;
          err_n     = 1'b0;
          start_n   = 1'b1;
          rd_en_n   = 1'b1;
          a_addr_n  = cmd_a_base;
          w_addr_n  = cmd_w_base;
          rd_last_n = (N_WORDS == 1);
          state_n   = START;
        end
      end
      START, ISSUE: begin
        if (dot_done) err_n = 1'b1;
        if (k == K_LAST) begin
          state_n = DRAIN;
        end else begin
          k_n       = k + 1'b1;
          rd_en_n   = 1'b1;
          a_addr_n  = a_base + ADDR_W'(k_n);
          w_addr_n  = w_base + ADDR_W'(k_n);
          rd_last_n = (k_n == K_LAST);
          state_n   = ISSUE;
        end
      end
      DRAIN: begin
        if (dot_done) err_n = 1'b1;
        if (word_valid && last_word) begin
          tmo_n   = '0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (dot_done) begin
          res_valid_n = 1'b1;
          res_data_n  = dot_acc;
          res_err_n   = err;
          state_n     = RESP;
        end else if ((DONE_TIMEOUT != 0) && (tmo == T_LAST)) begin
          err_n       = 1'b1;
          res_valid_n = 1'b1;
          res_data_n  = '0;
          res_err_n   = 1'b1;
          state_n     = RESP;
        end else if (tmo != '1) begin
          tmo_n = tmo + 1'b1;
        end
      end
      RESP: begin
        if (res_ready) begin
          res_valid_n = 1'b0;
          res_data_n  = '0;
          res_err_n   = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_base    <= '0;
      w_base    <= '0;
      k         <= '0;
      tmo       <= '0;
      err       <= 1'b0;
      start     <= 1'b0;
      rd_en     <= 1'b0;
      rd_last   <= 1'b0;
      a_rd_addr <= '0;
      w_rd_addr <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      a_base    <= a_base_n;
      w_base    <= w_base_n;
      k         <= k_n;
      tmo       <= tmo_n;
      err       <= err_n;
      start     <= start_n;
      rd_en     <= rd_en_n;
      rd_last   <= rd_last_n;
      a_rd_addr <= a_addr_n;
      w_rd_addr <= w_addr_n;
      res_valid <= res_valid_n;
      res_data  <= res_data_n;
      res_err   <= res_err_n;
      busy      <= busy_n;
    end
  end

  // Stage 1 tracks the memory latency, stage 2 registers the returned data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      l1         <= 1'b0;
      word_valid <= 1'b0;
      last_word  <= 1'b0;
      a_word     <= '0;
      w_word     <= '0;
    end else begin
      v1         <= rd_en;
      l1         <= rd_last;
      word_valid <= v1;
      last_word  <= v1 && l1;
      a_word     <= v1 ? a_rd_data : '0;
      w_word     <= v1 ? w_rd_data : '0;
    end
  end

endmodule

// File: tb/tb_bnn_dot_streamer.sv
// Directed bench for bnn_dot_streamer: a 2-word instance (timeout 8)
// and a 1-word instance, each fed by simple sync-read memory models.
module tb_bnn_dot_streamer;

  logic clk;
  logic rst_n;
  int checks;
  int passed;

  // Two-word instance signals
  logic        cmd_valid, cmd_ready;
  logic [9:0]  cmd_a_base, cmd_w_base;
  logic        a_rd_en, w_rd_en;
  logic [9:0]  a_rd_addr, w_rd_addr;
  logic [31:0] a_rd_data, w_rd_data;
  logic        start, word_valid, last_word;
  logic [31:0] a_word, w_word;
  logic        dot_done;
  logic signed [31:0] dot_acc, res_data;
  logic        res_valid, res_ready, res_err, busy;
  logic [31:0] a_mem [0:1023];
  logic [31:0] w_mem [0:1023];

  // Single-word instance signals
  logic        s_cmd_valid, s_cmd_ready;
  logic [9:0]  s_cmd_a_base, s_cmd_w_base;
  logic        s_a_rd_en, s_w_rd_en;
  logic [9:0]  s_a_rd_addr, s_w_rd_addr;
  logic [31:0] s_a_rd_data, s_w_rd_data;
  logic        s_start, s_word_valid, s_last_word;
  logic [31:0] s_a_word, s_w_word;
  logic        s_dot_done;
  logic signed [31:0] s_dot_acc, s_res_data;
  logic        s_res_valid, s_res_ready, s_res_err, s_busy;
  logic [31:0] s_a_mem [0:1023];
  logic [31:0] s_w_mem [0:1023];

  bnn_dot_streamer #(.N_BITS(64), .WORD_W(32), .ADDR_W(10), .DONE_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a_base(cmd_a_base), .cmd_w_base(cmd_w_base),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .start(start), .a_word(a_word), .w_word(w_word),
    .word_valid(word_valid), .last_word(last_word),
    .dot_done(dot_done), .dot_acc(dot_acc),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err), .busy(busy)
  );

  bnn_dot_streamer #(.N_BITS(32), .WORD_W(32), .ADDR_W(10), .DONE_TIMEOUT(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_a_base(s_cmd_a_base), .cmd_w_base(s_cmd_w_base),
    .a_rd_en(s_a_rd_en), .a_rd_addr(s_a_rd_addr), .a_rd_data(s_a_rd_data),
    .w_rd_en(s_w_rd_en), .w_rd_addr(s_w_rd_addr), .w_rd_data(s_w_rd_data),
    .start(s_start), .a_word(s_a_word), .w_word(s_w_word),
    .word_valid(s_word_valid), .last_word(s_last_word),
    .dot_done(s_dot_done), .dot_acc(s_dot_acc),
    .res_valid(s_res_valid), .res_ready(s_res_ready),
    .res_data(s_res_data), .res_err(s_res_err), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
    if (w_rd_en) w_rd_data <= w_mem[w_rd_addr];
    if (s_a_rd_en) s_a_rd_data <= s_a_mem[s_a_rd_addr];
    if (s_w_rd_en) s_w_rd_data <= s_w_mem[s_w_rd_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({cmd_ready, a_rd_en, w_rd_en, start, word_valid, last_word, res_valid, res_err, busy,
         a_rd_addr, w_rd_addr, a_word, w_word, res_data} !== '0)
      $display("[TB] FAIL reset_outputs: some output nonzero (cmd_ready=%b busy=%b res_valid=%b), want all 0",
               cmd_ready, busy, res_valid);
    else passed++;
    #9 rst_n = 1'b1;
    tick();
    checks++;
    if ({cmd_ready, busy, s_cmd_ready, s_busy} !== 4'b1010)
      $display("[TB] FAIL reset_release: got %b want 1010", {cmd_ready, busy, s_cmd_ready, s_busy});
    else passed++;
  endtask

  task automatic test_basic();
    cmd_a_base = 10'h010; cmd_w_base = 10'h200; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({start, a_rd_en, w_rd_en, cmd_ready, busy, a_rd_addr, w_rd_addr} !== {5'b11101, 10'h010, 10'h200})
      $display("[TB] FAIL basic_start: got %b %h %h want 11101 010 200",
               {start, a_rd_en, w_rd_en, cmd_ready, busy}, a_rd_addr, w_rd_addr);
    else passed++;
    tick();
    checks++;
    if ({start, a_rd_en, w_rd_en, a_rd_addr, w_rd_addr} !== {3'b011, 10'h011, 10'h201})
      $display("[TB] FAIL basic_issue: got %b %h %h want 011 011 201",
               {start, a_rd_en, w_rd_en}, a_rd_addr, w_rd_addr);
    else passed++;
    tick();
    checks++;
    if ({word_valid, last_word, a_rd_en, a_word, w_word} !== {3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF})
      $display("[TB] FAIL basic_word0: got %b %h %h want 100 ffffffff ffffffff",
               {word_valid, last_word, a_rd_en}, a_word, w_word);
    else passed++;
    tick();
    checks++;
    if ({word_valid, last_word, a_word, w_word} !== {2'b11, 32'h0000FFFF, 32'hFFFF0000})
      $display("[TB] FAIL basic_word1: got %b %h %h want 11 0000ffff ffff0000",
               {word_valid, last_word}, a_word, w_word);
    else passed++;
    tick();
    checks++;
    if ({word_valid, last_word, res_valid} !== 3'b000)
      $display("[TB] FAIL basic_wait: got %b want 000", {word_valid, last_word, res_valid});
    else passed++;
    dot_done = 1'b1; dot_acc = 32'sh20;
    tick();
    dot_done = 1'b0;
    checks++;
    if ({res_valid, res_err, res_data} !== {2'b10, 32'h00000020})
      $display("[TB] FAIL basic_result: got %b %h want 10 00000020", {res_valid, res_err}, res_data);
    else passed++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if ({res_valid, cmd_ready, busy} !== 3'b010)
      $display("[TB] FAIL basic_return_idle: got %b want 010", {res_valid, cmd_ready, busy});
    else passed++;
  endtask

  task automatic test_wrap();
    cmd_a_base = 10'h3FF; cmd_w_base = 10'h3FE; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({a_rd_addr, w_rd_addr} !== {10'h3FF, 10'h3FE})
      $display("[TB] FAIL wrap_first: got %h %h want 3ff 3fe", a_rd_addr, w_rd_addr);
    else passed++;
    tick();
    checks++;
    if ({a_rd_en, a_rd_addr, w_rd_addr} !== {1'b1, 10'h000, 10'h3FF})
      $display("[TB] FAIL wrap_second: got %b %h %h want 1 000 3ff", a_rd_en, a_rd_addr, w_rd_addr);
    else passed++;
    tick(); tick(); tick();
    dot_done = 1'b1; dot_acc = 32'sh1;
    tick();
    dot_done = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_single();
    s_cmd_a_base = 10'h020; s_cmd_w_base = 10'h040; s_cmd_valid = 1'b1;
    tick();
    s_cmd_valid = 1'b0;
    checks++;
    if ({s_start, s_a_rd_en, s_w_rd_en, s_a_rd_addr, s_w_rd_addr} !== {3'b111, 10'h020, 10'h040})
      $display("[TB] FAIL single_start: got %b %h %h want 111 020 040",
               {s_start, s_a_rd_en, s_w_rd_en}, s_a_rd_addr, s_w_rd_addr);
    else passed++;
    tick();
    checks++;
    if ({s_start, s_a_rd_en, s_word_valid} !== 3'b000)
      $display("[TB] FAIL single_gap: got %b want 000", {s_start, s_a_rd_en, s_word_valid});
    else passed++;
    tick();
    checks++;
    if ({s_word_valid, s_last_word, s_a_word, s_w_word} !== {2'b11, 32'h12345678, 32'h9ABCDEF0})
      $display("[TB] FAIL single_word: got %b %h %h want 11 12345678 9abcdef0",
               {s_word_valid, s_last_word}, s_a_word, s_w_word);
    else passed++;
    tick();
    s_dot_done = 1'b1; s_dot_acc = -32'sd5;
    tick();
    s_dot_done = 1'b0;
    checks++;
    if ({s_res_valid, s_res_err, s_res_data} !== {2'b10, 32'hFFFFFFFB})
      $display("[TB] FAIL single_result: got %b %h want 10 fffffffb", {s_res_valid, s_res_err}, s_res_data);
    else passed++;
    s_res_ready = 1'b1;
    tick();
    s_res_ready = 1'b0;
  endtask

  task automatic test_timeout();
    logic ok;
    cmd_a_base = 10'h010; cmd_w_base = 10'h200; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick(); tick();
    ok = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      if (res_valid !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) $display("[TB] FAIL timeout_early: res_valid seen before 8 wait cycles, want none");
    else passed++;
    tick();
    checks++;
    if ({res_valid, res_err, res_data} !== {2'b11, 32'h0})
      $display("[TB] FAIL timeout_result: got %b %h want 11 00000000", {res_valid, res_err}, res_data);
    else passed++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_early_done();
    cmd_a_base = 10'h010; cmd_w_base = 10'h200; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    dot_done = 1'b1; dot_acc = 32'sh99;
    tick();
    dot_done = 1'b0;
    tick(); tick();
    dot_done = 1'b1; dot_acc = 32'sh7;
    tick();
    dot_done = 1'b0;
    checks++;
    if ({res_valid, res_err, res_data} !== {2'b11, 32'h00000007})
      $display("[TB] FAIL early_done: got %b %h want 11 00000007", {res_valid, res_err}, res_data);
    else passed++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic ok;
    cmd_a_base = 10'h010; cmd_w_base = 10'h200; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick(); tick();
    dot_done = 1'b1; dot_acc = 32'sh80000001;
    tick();
    dot_done = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if ({res_valid, res_err, cmd_ready, res_data} !== {3'b100, 32'h80000001}) ok = 1'b0;
      tick();
    end
    checks++;
    if (ok !== 1'b1)
      $display("[TB] FAIL backpressure_hold: got %b %h want 100 80000001 for 5 cycles",
               {res_valid, res_err, cmd_ready}, res_data);
    else passed++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if ({res_valid, cmd_ready} !== 2'b01)
      $display("[TB] FAIL backpressure_release: got %b want 01", {res_valid, cmd_ready});
    else passed++;
  endtask

  task automatic test_reset_mid();
    cmd_a_base = 10'h010; cmd_w_base = 10'h200; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, a_rd_en, w_rd_en, start, word_valid, last_word, res_valid, res_err, busy,
         a_rd_addr, w_rd_addr, a_word, w_word, res_data} !== '0)
      $display("[TB] FAIL reset_mid_outputs: busy=%b a_rd_en=%b a_rd_addr=%h, want all 0",
               busy, a_rd_en, a_rd_addr);
    else passed++;
    #2 rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({cmd_ready, busy, word_valid, res_valid} !== 4'b1000)
      $display("[TB] FAIL reset_mid_idle: got %b want 1000", {cmd_ready, busy, word_valid, res_valid});
    else passed++;
    cmd_a_base = 10'h010; cmd_w_base = 10'h200; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    checks++;
    if ({word_valid, a_word, w_word} !== {1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF})
      $display("[TB] FAIL reset_mid_word0: got %b %h %h want 1 ffffffff ffffffff", word_valid, a_word, w_word);
    else passed++;
    tick(); tick();
    dot_done = 1'b1; dot_acc = 32'sh55;
    tick();
    dot_done = 1'b0;
    checks++;
    if ({res_valid, res_err, res_data} !== {2'b10, 32'h00000055})
      $display("[TB] FAIL reset_mid_result: got %b %h want 10 00000055", {res_valid, res_err}, res_data);
    else passed++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    checks = 0; passed = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_a_base = '0; cmd_w_base = '0;
    dot_done = 1'b0; dot_acc = '0; res_ready = 1'b0;
    s_cmd_valid = 1'b0; s_cmd_a_base = '0; s_cmd_w_base = '0;
    s_dot_done = 1'b0; s_dot_acc = '0; s_res_ready = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      a_mem[i] = '0; w_mem[i] = '0; s_a_mem[i] = '0; s_w_mem[i] = '0;
    end
    a_mem[10'h010] = 32'hFFFFFFFF; a_mem[10'h011] = 32'h0000FFFF;
    w_mem[10'h200] = 32'hFFFFFFFF; w_mem[10'h201] = 32'hFFFF0000;
    s_a_mem[10'h020] = 32'h12345678; s_w_mem[10'h040] = 32'h9ABCDEF0;

    test_reset();
    test_basic();
    test_wrap();
    test_single();
    test_timeout();
    test_early_done();
    test_backpressure();
    test_reset_mid();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bnn_dot_streamer.md
Name: bnn_dot_streamer

Overview:
Feeder and initiator side of the BNN dot-product word-stream interface. It accepts a command holding two base addresses and reads N_WORDS packed activation and weight words from two synchronous-read memories. It drives start, a_word/w_word, word_valid and last_word into bnn_dot_top, then waits for done and captures acc_out. The captured result is returned on a valid/ready result channel, with an error flag for timeout or protocol violation.

Parameters:
N_BITS, 256, dot-product length in bits; must be a multiple of WORD_W.
WORD_W, 32, packed word width.
N_WORDS, N_BITS/WORD_W, words per dot product; must be >= 1.
ADDR_W, 10, memory address width.
DONE_TIMEOUT, 1024, maximum cycles waited for dot_done after last_word; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_a_base  in  ADDR_W  activation base address
cmd_w_base  in  ADDR_W  weight base address
a_rd_en  out  1  activation memory read strobe
a_rd_addr  out  ADDR_W  activation read address
a_rd_data  in  WORD_W  activation data, valid the cycle after a_rd_en
w_rd_en  out  1  weight memory read strobe
w_rd_addr  out  ADDR_W  weight read address
w_rd_data  in  WORD_W  weight data, valid the cycle after w_rd_en
start  out  1  one-cycle pulse to dot engine
a_word  out  WORD_W  activation word to engine
w_word  out  WORD_W  weight word to engine
word_valid  out  1  word pair valid
last_word  out  1  final word of the vector, qualified by word_valid
dot_done  in  1  engine done pulse
dot_acc  in  32 signed  engine accumulator
res_valid  out  1  result valid
res_ready  in  1  result consumed
res_data  out  32 signed  captured accumulator
res_err  out  1  timeout or early-done error
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: asynchronous and active low. Every output is 0, the FSM goes to IDLE, and all counters clear. Reset mid-operation aborts the transaction silently; no result is produced.
- States: IDLE, START, ISSUE, DRAIN, WAIT, RESP. All outputs are registered except cmd_ready.
- IDLE: cmd_ready=1. On handshake, latch both base addresses, clear word counter k and the err flag, then go to START.
- START: start=1 for exactly this cycle; issue the read for word 0 (both rd_en=1, addr=base). If N_WORDS==1 go to DRAIN, else go to ISSUE.
- ISSUE: one read pair per cycle, no gaps, addr=base+k for k=1..N_WORDS-1. Addresses wrap modulo 2^ADDR_W. After word N_WORDS-1 is issued, go to DRAIN.
- Data path: rd_data is registered into a_word/w_word. word_valid asserts 2 cycles after the matching rd_en. last_word=1 only with word N_WORDS-1.
- Timing: word 0 is presented 2 cycles after start. The N_WORDS words appear on consecutive cycles, with no bubbles.
- DRAIN: leave when the last word is presented; go to WAIT and clear the timeout counter.
- WAIT: on dot_done, capture dot_acc into res_data and go to RESP. When DONE_TIMEOUT!=0 and the counter reaches DONE_TIMEOUT, set err, set res_data=0 and go to RESP.
- Early done: dot_done in START/ISSUE/DRAIN, including the last_word cycle, sets the sticky err flag. The FSM still waits in WAIT for a valid done or timeout.
- dot_done in IDLE or RESP is ignored.
- RESP: res_valid=1; res_data and res_err are held stable until res_ready. On res_valid && res_ready go to IDLE, so cmd_ready=1 on the next cycle.
- Throughput: minimum command-to-command spacing is N_WORDS+4 cycles plus engine latency plus res_ready delay.
- Width rules: k counter is $clog2(N_WORDS+1) bits. Timeout counter is $clog2(DONE_TIMEOUT+1) bits and saturates.

Decomposition:
- Shared bnn_dot_pkg: FSM state enum, an ACC_W=32 constant, and a word-count width helper function.
- bnn_dot_top and this block both import it.
- No sub-module: the read pipeline is two register stages inline, and a separate module adds nothing.

Test Plan:
1. Basic transfer. Config: N_BITS=64, WORD_W=32, a_base=0x010, w_base=0x200. Memories hold a=0xFFFFFFFF/0x0000FFFF and w=0xFFFFFFFF/0xFFFF0000. Response: reads at 0x010,0x011 / 0x200,0x201; word_valid for 2 consecutive cycles; last_word on the second cycle. Engine model returns dot_acc=0x00000020 → res_data=32, res_err=0.
2. Address wrap: a_base=0x3FF, N_WORDS=2 → a_rd_addr sequence is 0x3FF, 0x000.
3. Single word: N_BITS=WORD_W=32 → start and first read in the same cycle; word_valid and last_word together 2 cycles later.
4. Timeout: DONE_TIMEOUT=8 and the engine never signals done → res_valid with res_err=1, res_data=0, exactly 8 cycles after entering WAIT.
5. Early done: dot_done pulsed during ISSUE, then a valid done with 0x7 → res_data=7, res_err=1.
6. Backpressure and reset:
   - Hold res_ready=0 for 5 cycles → res_data stable, cmd_ready=0 throughout.
   - Deassert rst_n mid-ISSUE → all outputs 0 immediately; next command proceeds normally.
